// File: rtl/button_counter_pkg.sv
// Shared defaults and sizing helper for the button-controlled counter.
// Optional debounce stage is enabled with the BUTTON_COUNTER_DEBOUNCE_EN macro.
package button_counter_pkg;

  localparam int CNT_WIDTH_DEF       = 4;
  localparam int TICK_DIV_DEF        = 1;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  // Bits needed for a counter running 0..n-1; never less than one bit.
  function automatic int cntr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_counter_if.sv
// Button/count bundle between a board-side driver and the counter.
// The counter itself is unaffected by BUTTON_COUNTER_DEBOUNCE_EN at this level.
interface button_counter_if
  import button_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
);
  logic             button;
  logic [WIDTH-1:0] cnt;

  modport master (output button, input cnt);
  modport slave  (input button, output cnt);
endinterface

// File: rtl/button_press_detect.sv
// Synchronises a raw button and emits a one-cycle pulse per accepted rising level.
// With BUTTON_COUNTER_DEBOUNCE_EN defined, a debounce filter sits before the edge detect.
module button_press_detect
  import button_counter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef BUTTON_COUNTER_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic button_in,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level;
  logic                   level_prev_q, level_prev_d;

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], button_in};
    level_prev_d = level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      level_prev_q <= level_prev_d;
    end
  end

`ifdef BUTTON_COUNTER_DEBOUNCE_EN
  localparam int DW = cntr_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  // Any cycle where the synced input agrees with the accepted level restarts the run.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync_q[SYNC_STAGES-1] != deb_q) begin
      if (dcnt_q == DB_LAST) begin
        deb_d = sync_q[SYNC_STAGES-1];
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign level = deb_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  assign press = level & ~level_prev_q;

endmodule

// File: rtl/button_counter.sv
// Start/stop free-running counter: each button press toggles run, a prescaler paces cnt.
// Build with BUTTON_COUNTER_DEBOUNCE_EN to add a debounce filter on the button path.
module button_counter
  import button_counter_pkg::*;
#(
  parameter int WIDTH           = CNT_WIDTH_DEF,
  parameter int TICK_DIV        = TICK_DIV_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  output logic [WIDTH-1:0] cnt
);

  localparam int PW = cntr_width(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  // Illegal parameter combinations leave a distinctly named block in the hierarchy.
  if (TICK_DIV < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_illegal_params
  end

  logic             press;
  logic             tick;
  logic             run_q, run_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  button_press_detect #(
    .SYNC_STAGES     (SYNC_STAGES)
`ifdef BUTTON_COUNTER_DEBOUNCE_EN
    , .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
  ) u_press_detect (
    .clk       (clk),
    .rst       (rst),
    .button_in (button),
    .press     (press)
  );

  // The tick uses the pre-toggle run value, so a stopping press still counts its tick.
  always_comb begin
    tick    = run_q && (presc_q == TICK_LAST);
    presc_d = '0;
    if (run_q && !tick) begin
      presc_d = presc_q + 1'b1;
    end
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
    run_d = run_q ^ press;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      run_q   <= run_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_button_counter.sv
// Randomised scoreboard bench for button_counter against a cycle-level behavioural model.
// Model also covers the BUTTON_COUNTER_DEBOUNCE_EN build.
module tb_button_counter;
  import button_counter_pkg::*;

  localparam int W  = CNT_WIDTH_DEF;
  localparam int TD = TICK_DIV_DEF;
  localparam int S  = SYNC_STAGES_DEF;
  localparam int D  = DEBOUNCE_CYCLES_DEF;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;
  int   sb[$];

  button_counter_if #(.WIDTH(W)) bus ();

  button_counter #(
    .WIDTH           (W),
    .TICK_DIV        (TD),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .button (bus.button),
    .cnt    (bus.cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: hist[i] is the button value sampled i+1 edges ago.
  initial begin
    bit hist [0:S];
    bit run_m, press_m, acc_m, accp_m;
    int pre_m, cnt_m, diff_m;
    hist   = '{default: 1'b0};
    run_m  = 1'b0;
    acc_m  = 1'b0;
    accp_m = 1'b0;
    pre_m  = 0;
    cnt_m  = 0;
    diff_m = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        hist   = '{default: 1'b0};
        run_m  = 1'b0;
        acc_m  = 1'b0;
        accp_m = 1'b0;
        pre_m  = 0;
        cnt_m  = 0;
        diff_m = 0;
      end else begin
`ifdef BUTTON_COUNTER_DEBOUNCE_EN
        press_m = acc_m && !accp_m;
        accp_m  = acc_m;
        if (hist[S-1] != acc_m) begin
          diff_m++;
          if (diff_m == D) begin
            acc_m  = hist[S-1];
            diff_m = 0;
          end
        end else begin
          diff_m = 0;
        end
`else
        press_m = hist[S-1] && !hist[S];
`endif
        if (run_m) begin
          pre_m++;
          if (pre_m == TD) begin
            pre_m = 0;
            cnt_m = (cnt_m + 1) % (1 << W);
          end
        end else begin
          pre_m = 0;
        end
        if (press_m) run_m = !run_m;
        for (int i = S; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus.button;
      end
      sb.push_back(cnt_m);
    end
  end

  // Monitor: cnt is presented every cycle, compare one entry per edge.
  initial begin
    logic [W-1:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t actual cnt=%0d required an expected entry", $time, bus.cnt);
      end else begin
        exp_v = W'(sb.pop_front());
        if (bus.cnt !== exp_v) begin
          errors++;
          $display("FAIL cnt t=%0t actual=%0d required=%0d", $time, bus.cnt, exp_v);
        end
      end
    end
  end

  task automatic step(input logic b, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.button = b;
      rst        = r;
    end
    txn++;
    $display("txn %0d: button=%0b rst=%0b cycles=%0d cnt_now=%0d", txn, b, r, n, bus.cnt);
  endtask

  initial begin
    rst        = 1'b1;
    bus.button = 1'b0;
    // Reset then idle: no counting without a press.
    step(1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 10);
    // Start and run through a wrap.
    step(1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 20);
    // Stop, hold, resume.
    step(1'b1, 1'b0, 3);
    step(1'b0, 1'b0, 8);
    step(1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 10);
    // Reset mid-count, then a long hold gives a single press.
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 5);
    step(1'b1, 1'b0, 25);
    step(1'b0, 1'b0, 10);
    // Button held through reset release counts as a fresh press.
    step(1'b1, 1'b1, 2);
    step(1'b1, 1'b0, 10);
    step(1'b0, 1'b0, 6);
    // Random pulses, gaps and occasional resets.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        step(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(1, 2)));
      end else begin
        step(1'b1, 1'b0, int'($urandom_range(1, 8)));
        step(1'b0, 1'b0, int'($urandom_range(1, 30)));
      end
    end
    step(1'b0, 1'b0, 3);
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
